// File: rtl/map_writer.sv
// Map RAM writer: streams a full frame (LOAD, two pixels per byte) or paints a
// clipped rectangle (FILL) into a WIDTH x HEIGHT palette-index map.
module map_writer #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 90,
  parameter int PIX_BITS = 4,
  localparam int AW      = $clog2(WIDTH * HEIGHT)
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  input  logic                cmd_valid_in,
  output logic                cmd_ready_out,
  input  logic [1:0]          cmd_in,
  input  logic [7:0]          x0_in,
  input  logic [7:0]          x1_in,
  input  logic [6:0]          y0_in,
  input  logic [6:0]          y1_in,
  input  logic [PIX_BITS-1:0] color_in,
  input  logic                data_valid_in,
  output logic                data_ready_out,
  input  logic [7:0]          data_in,
  input  logic                abort_in,
  output logic                wr_en_out,
  output logic [AW-1:0]       wr_addr_out,
  output logic [PIX_BITS-1:0] wr_data_out,
  output logic                busy_out,
  output logic                done_out,
  output logic                err_out
);

  localparam int CW = (AW < 14) ? 14 : AW;
  localparam logic [CW-1:0] WCW = CW'(WIDTH);
  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [6:0] YMAX = 7'(HEIGHT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  typedef struct packed {
    logic [7:0]    x;
    logic [6:0]    y;
    logic [CW-1:0] a;
  } pos_t;

  // Raster advance inside the column window [lo, hi]; LOAD uses the full width.
  function automatic pos_t step(input pos_t p, input logic [7:0] lo, input logic [7:0] hi);
    step = p;
    if (p.x == hi) begin
      step.x = lo;
      step.y = p.y + 7'd1;
      step.a = p.a + WCW - CW'(hi - lo);
    end else begin
      step.x = p.x + 8'd1;
      step.a = p.a + CW'(1);
    end
  endfunction

  logic [1:0]          state_q, state_d;
  pos_t                pos_q, pos_d;
  logic [7:0]          fx0_q, fx0_d, fx1_q, fx1_d;
  logic [6:0]          fy1_q, fy1_d;
  logic [PIX_BITS-1:0] color_q, color_d;
  logic                hi_pend_q, hi_pend_d;
  logic [PIX_BITS-1:0] hi_nib_q, hi_nib_d;
  logic                fin_q, fin_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [PIX_BITS-1:0] wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [7:0] x1c;
  logic [6:0] y1c;
  logic       fill_bad;
  logic       last;
  pos_t       start;

  assign x1c      = (x1_in > XMAX) ? XMAX : x1_in;
  assign y1c      = (y1_in > YMAX) ? YMAX : y1_in;
  assign fill_bad = (x0_in > x1_in) || (y0_in > y1_in) || (x0_in > XMAX) || (y0_in > YMAX);
  assign last     = (pos_q.x == fx1_q) && (pos_q.y == fy1_q);

  always_comb begin
    start.x = x0_in;
    start.y = y0_in;
    start.a = CW'(y0_in) * WCW + CW'(x0_in);
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    fx0_d     = fx0_q;
    fx1_d     = fx1_q;
    fy1_d     = fy1_q;
    color_d   = color_q;
    hi_pend_d = hi_pend_q;
    hi_nib_d  = hi_nib_q;
    fin_d     = fin_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          err_d = 1'b0;
          case (cmd_in)
            2'd1: begin
              state_d   = S_LOAD;
              pos_d     = '0;
              fx0_d     = 8'd0;
              fx1_d     = XMAX;
              fy1_d     = YMAX;
              hi_pend_d = 1'b0;
              fin_d     = 1'b0;
            end
            2'd2: begin
              if (fill_bad) begin
                // Park in FILL for the done cycle so no command lands on top of it.
                state_d = S_FILL;
                err_d   = 1'b1;
                done_d  = 1'b1;
                fin_d   = 1'b1;
              end else begin
                state_d   = S_FILL;
                fx0_d     = x0_in;
                fx1_d     = x1c;
                fy1_d     = y1c;
                color_d   = color_in;
                wr_en_d   = 1'b1;
                wr_addr_d = start.a[AW-1:0];
                wr_data_d = color_in;
                pos_d     = step(start, x0_in, x1c);
                fin_d     = (x0_in == x1c) && (y0_in == y1c);
              end
            end
            2'd3: err_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: begin
        if (abort_in) begin
          state_d   = S_IDLE;
          hi_pend_d = 1'b0;
          fin_d     = 1'b0;
          err_d     = 1'b1;
        end else if (fin_q) begin
          state_d = S_IDLE;
          fin_d   = 1'b0;
          done_d  = !done_q;
        end else if (state_q == S_LOAD) begin
          if (hi_pend_q || data_valid_in) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pos_q.a[AW-1:0];
            wr_data_d = hi_pend_q ? hi_nib_q : PIX_BITS'(data_in[3:0]);
            hi_nib_d  = PIX_BITS'(data_in[7:4]);
            hi_pend_d = !hi_pend_q && !last;
            pos_d     = step(pos_q, fx0_q, fx1_q);
            fin_d     = last;
          end
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = pos_q.a[AW-1:0];
          wr_data_d = color_q;
          pos_d     = step(pos_q, fx0_q, fx1_q);
          fin_d     = last;
        end
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      fx0_q     <= '0;
      fx1_q     <= '0;
      fy1_q     <= '0;
      color_q   <= '0;
      hi_pend_q <= 1'b0;
      hi_nib_q  <= '0;
      fin_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      fx0_q     <= fx0_d;
      fx1_q     <= fx1_d;
      fy1_q     <= fy1_d;
      color_q   <= color_d;
      hi_pend_q <= hi_pend_d;
      hi_nib_q  <= hi_nib_d;
      fin_q     <= fin_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cmd_ready_out  = (state_q == S_IDLE);
  assign data_ready_out = (state_q == S_LOAD) && !hi_pend_q && !fin_q;
  assign busy_out       = (state_q != S_IDLE);
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign done_out       = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_map_writer.sv
// Directed bench for map_writer: FILL vector table plus LOAD, abort and reset sequences.
module tb_map_writer;
  localparam int W = 160;
  localparam int H = 90;
  localparam int PB = 4;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd = 2'd0;
  logic [7:0]    x0 = 8'd0, x1 = 8'd0;
  logic [6:0]    y0 = 7'd0, y1 = 7'd0;
  logic [PB-1:0] color = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [7:0]    data = 8'd0;
  logic          abort = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PB-1:0] wr_data;
  logic          busy, done, err;

  map_writer #(.WIDTH(W), .HEIGHT(H), .PIX_BITS(PB)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_in(cmd),
    .x0_in(x0), .x1_in(x1), .y0_in(y0), .y1_in(y1), .color_in(color),
    .data_valid_in(data_valid), .data_ready_out(data_ready), .data_in(data),
    .abort_in(abort), .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .busy_out(busy), .done_out(done), .err_out(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, x1, y0, y1, col;
    int n, first, last, err;
  } fvec_t;

  fvec_t vecs[9];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input fvec_t v);
    int q[$];
    int xe, ye, nw, mm, donec, firsta, lasta, errv;
    xe = (v.x1 > W - 1) ? W - 1 : v.x1;
    ye = (v.y1 > H - 1) ? H - 1 : v.y1;
    if (v.err == 0)
      for (int y = v.y0; y <= ye; y++)
        for (int x = v.x0; x <= xe; x++) q.push_back(y * W + x);
    cmd_valid = 1'b1; cmd = 2'd2;
    x0 = 8'(v.x0); x1 = 8'(v.x1); y0 = 7'(v.y0); y1 = 7'(v.y1); color = PB'(v.col);
    tick();
    cmd_valid = 1'b0;
    nw = 0; mm = 0; donec = 0; firsta = -1; lasta = -1; errv = -1;
    for (int c = 1; c <= 300; c++) begin
      if (wr_en) begin
        if (nw >= q.size() || int'(wr_addr) != q[nw] || int'(wr_data) != v.col) mm++;
        if (nw == 0) firsta = int'(wr_addr);
        lasta = int'(wr_addr);
        nw++;
      end
      if (done) begin
        donec = c;
        errv = int'(err);
        break;
      end
      tick();
    end
    chk("fill_writes", nw, v.n);
    chk("fill_done_cycle", donec, (v.n == 0) ? 1 : v.n + 1);
    chk("fill_err", errv, v.err);
    chk("fill_addr_seq_mismatches", mm, 0);
    if (v.n > 0) begin
      chk("fill_first_addr", firsta, v.first);
      chk("fill_last_addr", lasta, v.last);
    end
    tick();
    chk("fill_done_single", int'(done), 0);
    chk("fill_idle_after", int'(busy), 0);
  endtask

  initial begin
    int nw, mm, donec, lastwc, readies, consec, prevr, rc, extra;

    vecs[0] = '{x0:10,  x1:12,  y0:5,  y1:6,   col:7,  n:6,  first:810,   last:972,   err:0};
    vecs[1] = '{x0:150, x1:200, y0:89, y1:120, col:3,  n:10, first:14390, last:14399, err:0};
    vecs[2] = '{x0:20,  x1:10,  y0:0,  y1:0,   col:5,  n:0,  first:0,     last:0,     err:1};
    vecs[3] = '{x0:0,   x1:0,   y0:0,  y1:0,   col:9,  n:1,  first:0,     last:0,     err:0};
    vecs[4] = '{x0:160, x1:170, y0:0,  y1:1,   col:1,  n:0,  first:0,     last:0,     err:1};
    vecs[5] = '{x0:0,   x1:1,   y0:90, y1:95,  col:2,  n:0,  first:0,     last:0,     err:1};
    vecs[6] = '{x0:0,   x1:0,   y0:10, y1:9,   col:4,  n:0,  first:0,     last:0,     err:1};
    vecs[7] = '{x0:159, x1:255, y0:0,  y1:1,   col:15, n:2,  first:159,   last:319,   err:0};
    vecs[8] = '{x0:3,   x1:5,   y0:2,  y1:2,   col:6,  n:3,  first:323,   last:325,   err:0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data_ready", int'(data_ready), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_fill(vecs[i]);

    // bad FILL then NOP clears err
    cmd_valid = 1'b1; cmd = 2'd2; x0 = 8'd20; x1 = 8'd10; y0 = 7'd0; y1 = 7'd0;
    tick();
    cmd_valid = 1'b0;
    chk("badfill_err", int'(err), 1);
    tick();
    cmd_valid = 1'b1; cmd = 2'd0;
    tick();
    cmd_valid = 1'b0;
    chk("nop_clears_err", int'(err), 0);
    chk("nop_no_done", int'(done), 0);
    chk("nop_no_write", int'(wr_en), 0);
    chk("nop_idle", int'(busy), 0);

    // full LOAD of 0x21 bytes
    cmd_valid = 1'b1; cmd = 2'd1;
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1; data = 8'h21;
    nw = 0; mm = 0; donec = 0; lastwc = -5; readies = 0; consec = 0; prevr = 0;
    for (int c = 1; c <= 20000; c++) begin
      if (data_ready) begin
        readies++;
        if (prevr != 0) consec++;
      end
      prevr = int'(data_ready);
      if (wr_en) begin
        if (int'(wr_addr) != nw || int'(wr_data) != ((nw % 2 == 0) ? 1 : 2)) mm++;
        lastwc = c;
        nw++;
      end
      if (done) begin
        donec = c;
        break;
      end
      tick();
    end
    data_valid = 1'b0;
    chk("load_writes", nw, 14400);
    chk("load_seq_mismatches", mm, 0);
    chk("load_done_after_last", donec - lastwc, 1);
    chk("load_bytes_ready", readies, 7200);
    chk("load_ready_back_to_back", consec, 0);
    chk("load_idle_at_done", int'(busy), 0);
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      extra += int'(done) + int'(wr_en) + int'(data_ready);
    end
    chk("load_quiet_after", extra, 0);

    // abort on the third LOAD byte
    cmd_valid = 1'b1; cmd = 2'd1;
    tick();
    cmd_valid = 1'b0;
    data_valid = 1'b1; data = 8'h21;
    rc = 0; nw = 0;
    for (int c = 0; c < 30; c++) begin
      if (wr_en) nw++;
      if (data_ready) begin
        rc++;
        if (rc == 3) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          break;
        end
      end
      tick();
    end
    data_valid = 1'b0;
    chk("abort_prior_writes", nw, 4);
    chk("abort_idle", int'(busy), 0);
    chk("abort_err", int'(err), 1);
    chk("abort_no_write", int'(wr_en), 0);
    chk("abort_no_done", int'(done), 0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      extra += int'(done) + int'(wr_en);
    end
    chk("abort_quiet_after", extra, 0);

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_err_kept", int'(err), 1);
    chk("idle_abort_busy", int'(busy), 0);

    // new LOAD restarts at address 0
    cmd_valid = 1'b1; cmd = 2'd1;
    tick();
    cmd_valid = 1'b0;
    chk("reload_err_cleared", int'(err), 0);
    data_valid = 1'b1; data = 8'h43;
    tick();
    data_valid = 1'b0;
    chk("reload_wr_en", int'(wr_en), 1);
    chk("reload_addr0", int'(wr_addr), 0);
    chk("reload_lo", int'(wr_data), 3);
    tick();
    chk("reload_addr1", int'(wr_addr), 1);
    chk("reload_hi", int'(wr_data), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // reset in the middle of a FILL
    cmd_valid = 1'b1; cmd = 2'd2; x0 = 8'd0; x1 = 8'd159; y0 = 7'd0; y1 = 7'd89; color = 4'd5;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    chk("midfill_writing", int'(wr_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_wr_en", int'(wr_en), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk("post_rst_err", int'(err), 0);
    chk("post_rst_done", int'(done), 0);
    cmd_valid = 1'b1; cmd = 2'd3;
    tick();
    cmd_valid = 1'b0;
    chk("illegal_err", int'(err), 1);
    chk("illegal_busy", int'(busy), 0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      extra += int'(done) + int'(wr_en);
      tick();
    end
    chk("illegal_quiet", extra, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/map_writer.md
MAP_WRITER -- requirements
Module: map_writer

Interface
REQ-001 Parameter WIDTH, default 160: map width in pixels.
REQ-002 Parameter HEIGHT, default 90: map height in pixels.
REQ-003 Parameter PIX_BITS, default 4: palette index width per pixel.
REQ-004 pixel_clk_in  input  1: the only clock; all logic is on the rising edge.
REQ-005 rst_n_in  input  1: reset, asynchronous assert, active-low.
REQ-006 cmd_valid_in  input  1: command offered.
REQ-007 cmd_ready_out  output  1: command accepted this cycle if cmd_valid_in is also high.
REQ-008 cmd_in  input  2: 0 = NOP, 1 = LOAD full frame, 2 = FILL rectangle, 3 = illegal.
REQ-009 x0_in, x1_in  input  8 each: FILL column bounds, inclusive.
REQ-010 y0_in, y1_in  input  7 each: FILL row bounds, inclusive.
REQ-011 color_in  input  PIX_BITS: FILL colour.
REQ-012 data_valid_in  input  1: LOAD byte offered.
REQ-013 data_ready_out  output  1: LOAD byte accepted when data_valid_in is also high.
REQ-014 data_in  input  8: two pixels; low nibble is the earlier pixel.
REQ-015 abort_in  input  1: cancel the active operation.
REQ-016 wr_en_out  output  1: map RAM write strobe.
REQ-017 wr_addr_out  output  clog2(WIDTH*HEIGHT): write address, equal to y*WIDTH+x.
REQ-018 wr_data_out  output  PIX_BITS: write data.
REQ-019 busy_out  output  1: high in LOAD or FILL.
REQ-020 done_out  output  1: one-cycle completion pulse.
REQ-021 err_out  output  1: sticky error flag.

Function
REQ-022 The state machine SHALL have states IDLE, LOAD and FILL.
REQ-023 cmd_ready_out SHALL equal (state==IDLE); a command is taken on the edge where cmd_valid_in and cmd_ready_out are both high.
REQ-024 Every accepted command SHALL clear err_out on the same edge, then evaluate as follows.
- NOP: stays in IDLE, no writes, no done_out.
- Illegal (3): stays in IDLE, sets err_out, no done_out.
REQ-025 LOAD SHALL set x=0 and y=0, then enter LOAD.
REQ-026 In LOAD, data_ready_out SHALL equal (state==LOAD) and no high nibble pending, which limits throughput to one byte every 2 cycles.
REQ-027 For a byte accepted at edge k, the following SHALL hold.
- Cycle k+1: wr_en_out=1, wr_data_out=data_in[3:0].
- Cycle k+2: wr_en_out=1, wr_data_out=data_in[7:4].
- The address advances x-first and wraps x at WIDTH-1 to the next y.
REQ-028 LOAD SHALL finish after WIDTH*HEIGHT writes (7200 bytes at defaults).
- done_out pulses in the cycle after the last write.
- The state returns to IDLE on that same edge.
- No further bytes are accepted.
REQ-029 FILL with x0>x1, y0>y1, x0>=WIDTH or y0>=HEIGHT SHALL set err_out, perform no writes, and pulse done_out one cycle after acceptance.
REQ-030 Otherwise, FILL SHALL clip x1 to WIDTH-1 and y1 to HEIGHT-1 and latch all bounds and the colour at acceptance.
- It writes color_in in raster order at one pixel per cycle.
- The first write is in the cycle after acceptance.
- done_out pulses in the cycle after the last write.
REQ-031 wr_en_out, wr_addr_out and wr_data_out SHALL be registered, and wr_en_out SHALL be 0 in IDLE.
REQ-032 When abort_in is sampled high in LOAD or FILL, the block SHALL:
- enter IDLE on that edge;
- drop any pending high nibble;
- set err_out;
- not pulse done_out;
- not write in the following cycle.
REQ-033 abort_in in IDLE SHALL have no effect.
REQ-034 busy_out SHALL equal (state!=IDLE), and done_out SHALL never be high for 2 consecutive cycles.
REQ-035 Address arithmetic SHALL use at least 14 bits so that WIDTH*HEIGHT-1=14399 never wraps.

Reset
REQ-036 While rst_n_in is low, the block SHALL be in IDLE with the following outputs.
- wr_en_out=0, wr_addr_out=0, wr_data_out=0, done_out=0, err_out=0, busy_out=0, data_ready_out=0.
- cmd_ready_out=1.
REQ-037 Reset asserted mid-LOAD or mid-FILL SHALL drop wr_en_out immediately (asynchronously), with no done_out afterwards.

Verification
REQ-038 LOAD, then 7200 bytes 0x21 with data_valid_in held high:
- writes alternate 1,2;
- wr_addr_out runs 0..14399;
- done_out pulses once, one cycle after address 14399;
- each byte sees data_ready_out high every other cycle.
REQ-039 FILL x0=10, x1=12, y0=5, y1=6, colour 7:
- 6 writes on consecutive cycles at addresses 810, 811, 812, 970, 971, 972;
- done_out pulses the next cycle.
REQ-040 FILL x0=150, x1=200, y0=89, y1=120, colour 3: writes at 14390..14399 only, then done_out.
REQ-041 FILL x0=20, x1=10: err_out=1, zero writes, done_out one cycle after acceptance; a following NOP clears err_out.
REQ-042 abort_in on the 3rd LOAD byte: IDLE next edge, err_out=1, no done_out; a new LOAD restarts at address 0.
REQ-043 rst_n_in pulsed low mid-FILL: wr_en_out=0 immediately; after release cmd_ready_out=1 and err_out=0; cmd_in=3 then sets err_out with no writes.
